// File: rtl/mem_ss_health_pkg.sv
// Shared types and helpers for the memory-subsystem health sequencer.
// The state type doubles as the CSR encoding of each device's health.
package mem_ss_health_pkg;

    localparam int RETRY_W = 2;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_CAL   = 3'd1,
        ST_READY      = 3'd2,
        ST_FAILED     = 3'd3,
        ST_TIMEOUT    = 3'd4,
        ST_TRIPPED    = 3'd5
    } t_dev_state;

    function automatic logic [2:0] state_to_csr(input t_dev_state s);
        return 3'(s);
    endfunction

    function automatic logic is_error_state(input t_dev_state s);
        return (s == ST_FAILED) || (s == ST_TIMEOUT) || (s == ST_TRIPPED);
    endfunction

endpackage

// File: rtl/mem_ss_dev_health_fsm.sv
// Per-device calibration sequencer: reset hold, calibration timeout, bounded
// retry, thermal trip and a filtered over-temperature warning.
module mem_ss_dev_health_fsm
    import mem_ss_health_pkg::*;
#(
    parameter int          RST_HOLD_CYC     = 64,
    parameter int          CAL_TIMEOUT_CYC  = 1048576,
    parameter int          MAX_RETRY        = 2,
    parameter logic [2:0]  TEMP_WARN_THRESH = 3'd5,
    parameter int          TEMP_FILTER_CYC  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cal_success,
    input  logic               cal_fail,
    input  logic               cattrip,
    input  logic [2:0]         temp,
    input  logic               restart,
    output logic               dev_rst,
    output logic               chan_en,
    output logic [2:0]         dev_state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               temp_warn,
    output logic               ready_nxt,
    output logic               error_nxt
);

    localparam int LIMIT_MAX = (RST_HOLD_CYC > CAL_TIMEOUT_CYC) ? RST_HOLD_CYC : CAL_TIMEOUT_CYC;
    localparam int CNT_W     = $clog2(LIMIT_MAX) + 1;
    localparam int TF_W      = $clog2(TEMP_FILTER_CYC + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(CAL_TIMEOUT_CYC - 1);
    localparam logic [TF_W-1:0]    TF_FULL   = TF_W'(TEMP_FILTER_CYC);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    t_dev_state         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [TF_W-1:0]    tf_q, tf_d;
    logic               warn_q, warn_d;
    logic               dev_rst_q, dev_rst_d;
    logic               chan_en_q, chan_en_d;
    logic               retry_req;
    logic               retry_tmo;
    logic               hot;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        retry_req = 1'b0;
        retry_tmo = 1'b0;

        case (state_q)
            ST_RESET_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_WAIT_CAL;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_CAL: begin
                if (cal_fail) begin
                    retry_req = 1'b1;
                end else if (cal_success) begin
                    state_d = ST_READY;
                end else if (cnt_q == TMO_LAST) begin
                    retry_req = 1'b1;
                    retry_tmo = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (!cal_success || cal_fail) state_d = ST_FAILED;
            end
            ST_FAILED, ST_TIMEOUT: begin
                if (restart) begin
                    state_d = ST_RESET_HOLD;
                    retry_d = '0;
                end
            end
            default: ;
        endcase

        if (retry_req) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_RESET_HOLD;
            end else begin
                state_d = retry_tmo ? ST_TIMEOUT : ST_FAILED;
            end
        end

        if (cattrip) state_d = ST_TRIPPED;

        // Every state entry restarts the hold/timeout count, so it never wraps.
        if (state_d != state_q) cnt_d = '0;

        dev_rst_d = !(state_d inside {ST_WAIT_CAL, ST_READY});
        chan_en_d = (state_d == ST_READY);
        ready_nxt = (state_d == ST_READY);
        error_nxt = is_error_state(state_d);

        hot    = (temp >= TEMP_WARN_THRESH);
        tf_d   = hot ? ((tf_q == TF_FULL) ? tf_q : tf_q + 1'b1) : '0;
        warn_d = hot && (tf_d == TF_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESET_HOLD;
            cnt_q     <= '0;
            retry_q   <= '0;
            tf_q      <= '0;
            warn_q    <= 1'b0;
            dev_rst_q <= 1'b1;
            chan_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            tf_q      <= tf_d;
            warn_q    <= warn_d;
            dev_rst_q <= dev_rst_d;
            chan_en_q <= chan_en_d;
        end
    end

    assign dev_rst   = dev_rst_q;
    assign chan_en   = chan_en_q;
    assign dev_state = state_to_csr(state_q);
    assign retry_cnt = retry_q;
    assign temp_warn = warn_q;

endmodule

// File: rtl/mem_ss_health_mon.sv
// Memory-subsystem health monitor: one sequencer per device, AFU channel
// reset fan-out, and registered all-ready / any-error summaries.
module mem_ss_health_mon
    import mem_ss_health_pkg::*;
#(
    parameter int          NUM_MEM_DEVICES  = 2,
    parameter int          CH_PER_DEVICE    = 16,
    parameter int          RST_HOLD_CYC     = 64,
    parameter int          CAL_TIMEOUT_CYC  = 1048576,
    parameter int          MAX_RETRY        = 2,
    parameter logic [2:0]  TEMP_WARN_THRESH = 3'd5,
    parameter int          TEMP_FILTER_CYC  = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_MEM_DEVICES-1:0]                    cal_success,
    input  logic [NUM_MEM_DEVICES-1:0]                    cal_fail,
    input  logic [NUM_MEM_DEVICES-1:0]                    cattrip,
    input  logic [NUM_MEM_DEVICES-1:0][2:0]               temp,
    input  logic [NUM_MEM_DEVICES-1:0]                    restart,
    output logic [NUM_MEM_DEVICES-1:0]                    dev_rst,
    output logic [NUM_MEM_DEVICES*CH_PER_DEVICE-1:0]      chan_rst_n,
    output logic [NUM_MEM_DEVICES-1:0][2:0]               dev_state,
    output logic [NUM_MEM_DEVICES-1:0][RETRY_W-1:0]       retry_cnt,
    output logic [NUM_MEM_DEVICES-1:0]                    temp_warn,
    output logic                                          all_ready,
    output logic                                          any_error
);

    logic [NUM_MEM_DEVICES-1:0] chan_en;
    logic [NUM_MEM_DEVICES-1:0] ready_nxt;
    logic [NUM_MEM_DEVICES-1:0] error_nxt;
    logic                       all_ready_q, all_ready_d;
    logic                       any_error_q, any_error_d;

    for (genvar d = 0; d < NUM_MEM_DEVICES; d++) begin : g_dev
        mem_ss_dev_health_fsm #(
            .RST_HOLD_CYC     (RST_HOLD_CYC),
            .CAL_TIMEOUT_CYC  (CAL_TIMEOUT_CYC),
            .MAX_RETRY        (MAX_RETRY),
            .TEMP_WARN_THRESH (TEMP_WARN_THRESH),
            .TEMP_FILTER_CYC  (TEMP_FILTER_CYC)
        ) u_fsm (
            .clk         (clk),
            .reset       (reset),
            .cal_success (cal_success[d]),
            .cal_fail    (cal_fail[d]),
            .cattrip     (cattrip[d]),
            .temp        (temp[d]),
            .restart     (restart[d]),
            .dev_rst     (dev_rst[d]),
            .chan_en     (chan_en[d]),
            .dev_state   (dev_state[d]),
            .retry_cnt   (retry_cnt[d]),
            .temp_warn   (temp_warn[d]),
            .ready_nxt   (ready_nxt[d]),
            .error_nxt   (error_nxt[d])
        );

        assign chan_rst_n[d*CH_PER_DEVICE +: CH_PER_DEVICE] = {CH_PER_DEVICE{chan_en[d]}};
    end

    // Reducing next-state flags keeps the summaries aligned with dev_state.
    always_comb begin
        all_ready_d = &ready_nxt;
        any_error_d = |error_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            all_ready_q <= 1'b0;
            any_error_q <= 1'b0;
        end else begin
            all_ready_q <= all_ready_d;
            any_error_q <= any_error_d;
        end
    end

    assign all_ready = all_ready_q;
    assign any_error = any_error_q;

endmodule

// File: tb/tb_mem_ss_health_mon.sv
// Directed bench for mem_ss_health_mon: a cycle model predicts every output,
// and literal expectations pin latencies, counts and boundary behaviour.
module tb_mem_ss_health_mon;

    localparam int N    = 2;
    localparam int CH   = 4;
    localparam int HOLD = 8;
    localparam int TMO  = 100;
    localparam int MAXR = 2;
    localparam int TFC  = 4;
    localparam int THR  = 5;

    localparam int S_HOLD = 0, S_WAIT = 1, S_READY = 2, S_FAIL = 3, S_TMO = 4, S_TRIP = 5;

    typedef struct packed {
        logic [N-1:0][2:0] st;
        logic [N-1:0][1:0] rc;
        logic [N-1:0]      warn;
        logic [N-1:0]      rst;
        logic [N*CH-1:0]   chan;
        logic              ar;
        logic              ae;
    } t_obs;

    localparam int OBS_W = $bits(t_obs);

    logic                clk;
    logic                reset;
    logic [N-1:0]        cal_success;
    logic [N-1:0]        cal_fail;
    logic [N-1:0]        cattrip;
    logic [N-1:0][2:0]   temp;
    logic [N-1:0]        restart;
    logic [N-1:0]        dev_rst;
    logic [N*CH-1:0]     chan_rst_n;
    logic [N-1:0][2:0]   dev_state;
    logic [N-1:0][1:0]   retry_cnt;
    logic [N-1:0]        temp_warn;
    logic                all_ready;
    logic                any_error;

    int vectors    = 0;
    int miscompares = 0;

    logic [OBS_W-1:0] exp_q[$];

    int m_state[N];
    int m_age[N];
    int m_retry[N];
    int m_hot[N];
    bit m_warn[N];

    mem_ss_health_mon #(
        .NUM_MEM_DEVICES  (N),
        .CH_PER_DEVICE    (CH),
        .RST_HOLD_CYC     (HOLD),
        .CAL_TIMEOUT_CYC  (TMO),
        .MAX_RETRY        (MAXR),
        .TEMP_WARN_THRESH (3'd5),
        .TEMP_FILTER_CYC  (TFC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cal_success (cal_success),
        .cal_fail    (cal_fail),
        .cattrip     (cattrip),
        .temp        (temp),
        .restart     (restart),
        .dev_rst     (dev_rst),
        .chan_rst_n  (chan_rst_n),
        .dev_state   (dev_state),
        .retry_cnt   (retry_cnt),
        .temp_warn   (temp_warn),
        .all_ready   (all_ready),
        .any_error   (any_error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    task automatic enter(input int d, input int s);
        m_state[d] = s;
        m_age[d]   = 0;
    endtask

    task automatic retry_or_stop(input int d, input int final_s);
        if (m_retry[d] < MAXR) begin
            m_retry[d]++;
            enter(d, S_HOLD);
        end else begin
            enter(d, final_s);
        end
    endtask

    task automatic step_dev(input int d);
        bit hot;
        hot = (int'(temp[d]) >= THR);
        m_hot[d]  = hot ? ((m_hot[d] < TFC) ? m_hot[d] + 1 : TFC) : 0;
        m_warn[d] = hot && (m_hot[d] >= TFC);
        if (cattrip[d]) begin
            enter(d, S_TRIP);
        end else begin
            case (m_state[d])
                S_HOLD:  if (m_age[d] == HOLD - 1) enter(d, S_WAIT); else m_age[d]++;
                S_WAIT: begin
                    if (cal_fail[d])               retry_or_stop(d, S_FAIL);
                    else if (cal_success[d])       enter(d, S_READY);
                    else if (m_age[d] == TMO - 1)  retry_or_stop(d, S_TMO);
                    else                           m_age[d]++;
                end
                S_READY: if (!cal_success[d] || cal_fail[d]) enter(d, S_FAIL);
                S_FAIL, S_TMO: if (restart[d]) begin m_retry[d] = 0; enter(d, S_HOLD); end
                default: ;
            endcase
        end
    endtask

    initial begin
        t_obs e;
        forever begin
            @(posedge clk);
            for (int d = 0; d < N; d++) begin
                if (reset) begin
                    enter(d, S_HOLD);
                    m_retry[d] = 0;
                    m_hot[d]   = 0;
                    m_warn[d]  = 1'b0;
                end else begin
                    step_dev(d);
                end
            end
            e    = '0;
            e.ar = 1'b1;
            for (int d = 0; d < N; d++) begin
                e.st[d]   = 3'(m_state[d]);
                e.rc[d]   = 2'(m_retry[d]);
                e.warn[d] = m_warn[d];
                e.rst[d]  = !(m_state[d] == S_WAIT || m_state[d] == S_READY);
                for (int c = 0; c < CH; c++) e.chan[d*CH + c] = (m_state[d] == S_READY);
                if (m_state[d] != S_READY) e.ar = 1'b0;
                if (m_state[d] >= S_FAIL) e.ae = 1'b1;
            end
            exp_q.push_back(OBS_W'(e));
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        t_obs e;
        t_obs a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = t_obs'(exp_q.pop_front());
                a = '{st: dev_state, rc: retry_cnt, warn: temp_warn, rst: dev_rst,
                      chan: chan_rst_n, ar: all_ready, ae: any_error};
                vectors++;
                if (a.st !== e.st) begin miscompares++; $display("FAIL dev_state t=%0t: got %h, expected %h", $time, a.st, e.st); end
                if (a.rc !== e.rc) begin miscompares++; $display("FAIL retry_cnt t=%0t: got %h, expected %h", $time, a.rc, e.rc); end
                if (a.warn !== e.warn) begin miscompares++; $display("FAIL temp_warn t=%0t: got %b, expected %b", $time, a.warn, e.warn); end
                if (a.rst !== e.rst) begin miscompares++; $display("FAIL dev_rst t=%0t: got %b, expected %b", $time, a.rst, e.rst); end
                if (a.chan !== e.chan) begin miscompares++; $display("FAIL chan_rst_n t=%0t: got %h, expected %h", $time, a.chan, e.chan); end
                if (a.ar !== e.ar) begin miscompares++; $display("FAIL all_ready t=%0t: got %b, expected %b", $time, a.ar, e.ar); end
                if (a.ae !== e.ae) begin miscompares++; $display("FAIL any_error t=%0t: got %b, expected %b", $time, a.ae, e.ae); end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input int d, input int s, input int limit);
        int n;
        n = 0;
        while (int'(dev_state[d]) != s && n < limit) begin
            tick(1);
            n++;
        end
        chk($sformatf("wait dev%0d state %0d", d, s), 32'(dev_state[d]), 32'(s));
    endtask

    task automatic pulse_restart(input int d);
        restart[d] = 1'b1;
        tick(1);
        restart[d] = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        reset       = 1'b1;
        cal_success = '0;
        cal_fail    = '0;
        cattrip     = '0;
        temp        = '0;
        restart     = '0;
        tick(3);
        chk("reset dev_state", 32'(dev_state), 32'h0);
        chk("reset dev_rst", 32'(dev_rst), 32'h3);
        chk("reset chan_rst_n", 32'(chan_rst_n), 32'h0);
        reset = 1'b0;

        // 1: hold length, then success 20 cycles into WAIT_CAL
        n = 0;
        while (dev_rst[0] && n < 30) begin n++; tick(1); end
        chk("dev_rst hold cycles", 32'(n), 32'd8);
        chk("enter WAIT_CAL", 32'(dev_state[0]), 32'd1);
        tick(20);
        cal_success[0] = 1'b1;
        chk("still WAIT_CAL", 32'(dev_state[0]), 32'd1);
        tick(1);
        chk("READY after success", 32'(dev_state[0]), 32'd2);
        chk("chan_rst_n dev0 only", 32'(chan_rst_n), 32'h0F);

        // 2: READY loss, then repeated cal_fail through all retries
        cal_success[0] = 1'b0;
        tick(1);
        chk("READY drop to FAILED", 32'(dev_state[0]), 32'd3);
        chk("no retry from READY", 32'(retry_cnt[0]), 32'd0);
        pulse_restart(0);
        chk("restart to RESET_HOLD", 32'(dev_state[0]), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            wait_state(0, S_WAIT, 20);
            cal_fail[0] = 1'b1;
            tick(1);
            cal_fail[0] = 1'b0;
            if (k < 3) begin
                chk($sformatf("fail retry_cnt %0d", k), 32'(retry_cnt[0]), 32'(k));
                chk("fail back to hold", 32'(dev_state[0]), 32'd0);
            end else begin
                chk("final FAILED", 32'(dev_state[0]), 32'd3);
                chk("FAILED retry_cnt", 32'(retry_cnt[0]), 32'd2);
                chk("FAILED any_error", 32'(any_error), 32'd1);
            end
        end
        pulse_restart(0);
        chk("restart clears retry", 32'(retry_cnt[0]), 32'd0);
        chk("restart state", 32'(dev_state[0]), 32'd0);

        // 3: three timeouts, then success on the expiry cycle
        wait_state(0, S_WAIT, 20);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (dev_state[0] == 3'd1 && n < 200) begin n++; tick(1); end
            chk($sformatf("timeout length %0d", k), 32'(n), 32'd100);
            if (k < 2) begin
                chk($sformatf("timeout retry_cnt %0d", k), 32'(retry_cnt[0]), 32'(k + 1));
                wait_state(0, S_WAIT, 20);
            end else begin
                chk("final TIMEOUT", 32'(dev_state[0]), 32'd4);
            end
        end
        pulse_restart(0);
        wait_state(0, S_WAIT, 20);
        tick(99);
        cal_success[0] = 1'b1;
        tick(1);
        chk("success beats expiry", 32'(dev_state[0]), 32'd2);
        chk("expiry retry_cnt", 32'(retry_cnt[0]), 32'd0);

        // 4: both READY, then thermal trip on device 1
        wait_state(1, S_TMO, 1000);
        pulse_restart(1);
        wait_state(1, S_WAIT, 20);
        cal_success[1] = 1'b1;
        tick(1);
        chk("both all_ready", 32'(all_ready), 32'd1);
        chk("both chan_rst_n", 32'(chan_rst_n), 32'hFF);
        cattrip[1] = 1'b1;
        tick(1);
        cattrip[1] = 1'b0;
        chk("TRIPPED", 32'(dev_state[1]), 32'd5);
        chk("trip chan_rst_n", 32'(chan_rst_n), 32'h0F);
        chk("trip all_ready", 32'(all_ready), 32'd0);
        chk("trip dev_rst", 32'(dev_rst), 32'h2);
        pulse_restart(1);
        chk("restart ignored in TRIPPED", 32'(dev_state[1]), 32'd5);
        chk("dev0 unaffected", 32'(dev_state[0]), 32'd2);
        reset = 1'b1;
        cal_success = '0;
        tick(1);
        chk("reset exits TRIPPED", 32'(dev_state), 32'h0);
        tick(1);
        reset = 1'b0;

        // 5: thermal filter
        temp[0] = 3'd5;
        tick(3);
        temp[0] = 3'd4;
        chk("warn after 3 hot", 32'(temp_warn[0]), 32'd0);
        tick(1);
        chk("warn after cool", 32'(temp_warn[0]), 32'd0);
        temp[0] = 3'd6;
        tick(4);
        chk("warn after 4 hot", 32'(temp_warn[0]), 32'd1);
        tick(2);
        chk("warn held while hot", 32'(temp_warn[0]), 32'd1);
        temp[0] = 3'd2;
        tick(1);
        chk("warn clears", 32'(temp_warn[0]), 32'd0);

        // 6: fail wins over success; reset out of READY
        wait_state(0, S_WAIT, 50);
        cal_success[0] = 1'b1;
        cal_fail[0]    = 1'b1;
        tick(1);
        cal_success[0] = 1'b0;
        cal_fail[0]    = 1'b0;
        chk("fail wins retry_cnt", 32'(retry_cnt[0]), 32'd1);
        chk("fail wins state", 32'(dev_state[0]), 32'd0);
        wait_state(0, S_WAIT, 50);
        cal_success[0] = 1'b1;
        temp[1] = 3'd7;
        tick(1);
        chk("READY before reset", 32'(dev_state[0]), 32'd2);
        tick(5);
        chk("dev1 warn before reset", 32'(temp_warn[1]), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("rst dev_state", 32'(dev_state), 32'h0);
        chk("rst dev_rst", 32'(dev_rst), 32'h3);
        chk("rst chan_rst_n", 32'(chan_rst_n), 32'h0);
        chk("rst retry_cnt", 32'(retry_cnt), 32'h0);
        chk("rst temp_warn", 32'(temp_warn), 32'h0);
        chk("rst all_ready", 32'(all_ready), 32'd0);
        chk("rst any_error", 32'(any_error), 32'd0);
        cal_success = '0;
        temp        = '0;
        tick(2);
        reset = 1'b0;
        tick(3);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
